// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - RV32I register file with bypassed reads and pending-writer scoreboard
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              reg_write_w,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic [DATA_W-1:0] result_w,
  input  logic [ADDR_W-1:0] rs1_d,
  input  logic [ADDR_W-1:0] rs2_d,
  input  logic              use_rs1_d,
  input  logic              use_rs2_d,
  output logic [DATA_W-1:0] rd1_d,
  output logic [DATA_W-1:0] rd2_d,
  input  logic              issue_d,
  input  logic [ADDR_W-1:0] issue_rd_d,
  input  logic              issue_reg_write_d,
  input  logic              kill_valid,
  input  logic [ADDR_W-1:0] kill_rd,
  output logic              stall_d,
  output logic              sb_err
);

  logic [DATA_W-1:0] regs    [NUM_REGS];
  logic [CNT_W-1:0]  cnt     [NUM_REGS];
  logic [CNT_W-1:0]  cnt_nxt [NUM_REGS];

  logic [NUM_REGS-1:0] under_v;
  logic [NUM_REGS-1:0] over_v;
  logic [NUM_REGS-1:0] pend_v;

  // Per-register arithmetic runs two bits wider so the sign bit flags underflow
  // and bit CNT_W (with a clear sign) flags overflow.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic             inc;
    logic             dw;
    logic             dk;
    logic [CNT_W+1:0] sum;
    logic [CNT_W+1:0] eff;

    assign inc = (g != 0) && issue_d && issue_reg_write_d && (issue_rd_d == ADDR_W'(g));
    assign dw  = (g != 0) && reg_write_w && (rd_w == ADDR_W'(g));
    assign dk  = (g != 0) && kill_valid && (kill_rd == ADDR_W'(g));

    assign sum = {2'b00, cnt[g]} + {{(CNT_W+1){1'b0}}, inc}
               - {{(CNT_W+1){1'b0}}, dw} - {{(CNT_W+1){1'b0}}, dk};
    assign eff = {2'b00, cnt[g]} - {{(CNT_W+1){1'b0}}, dw} - {{(CNT_W+1){1'b0}}, dk};

    assign under_v[g] = sum[CNT_W+1];
    assign over_v[g]  = !sum[CNT_W+1] && sum[CNT_W];
    assign pend_v[g]  = !eff[CNT_W+1] && (eff != '0);

    assign cnt_nxt[g] = under_v[g] ? '0 :
                        over_v[g]  ? {CNT_W{1'b1}} :
                                     sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (reg_write_w && (rd_w != '0)) begin
        regs[rd_w] <= result_w;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      sb_err <= sb_err | (|under_v) | (|over_v);
    end
  end

  // Write-first bypass so a value retiring this cycle is visible to decode.
  always_comb begin
    rd1_d = regs[rs1_d];
    if (rs1_d == '0) begin
      rd1_d = '0;
    end else if (reg_write_w && (rd_w == rs1_d)) begin
      rd1_d = result_w;
    end
  end

  always_comb begin
    rd2_d = regs[rs2_d];
    if (rs2_d == '0) begin
      rd2_d = '0;
    end else if (reg_write_w && (rd_w == rs2_d)) begin
      rd2_d = result_w;
    end
  end

  assign stall_d = (use_rs1_d && (rs1_d != '0) && pend_v[rs1_d])
                || (use_rs2_d && (rs2_d != '0) && pend_v[rs2_d]);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        srst_n;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic [4:0]  rs1_d, rs2_d;
  logic        use_rs1_d, use_rs2_d;
  logic [31:0] rd1_d, rd2_d;
  logic        issue_d;
  logic [4:0]  issue_rd_d;
  logic        issue_reg_write_d;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        stall_d;
  logic        sb_err;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard dut (
    .clk(clk), .srst_n(srst_n),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d),
    .issue_d(issue_d), .issue_rd_d(issue_rd_d), .issue_reg_write_d(issue_reg_write_d),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .stall_d(stall_d), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  // Reference model: architectural values, in-flight writer counts, sticky error.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_err;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (reg_write_w && rd_w == idx) return result_w;
    return m_regs[idx];
  endfunction

  function automatic int m_eff(input logic [4:0] idx);
    int e;
    e = m_cnt[idx];
    if (idx != 0 && reg_write_w && rd_w == idx) e--;
    if (idx != 0 && kill_valid && kill_rd == idx) e--;
    return e;
  endfunction

  function automatic logic m_stall();
    return (use_rs1_d && rs1_d != 0 && m_eff(rs1_d) > 0) ||
           (use_rs2_d && rs2_d != 0 && m_eff(rs2_d) > 0);
  endfunction

  task automatic model_step();
    int n;
    for (int r = 1; r < 32; r++) begin
      n = m_cnt[r];
      if (issue_d && issue_reg_write_d && issue_rd_d == r) n++;
      if (reg_write_w && rd_w == r) n--;
      if (kill_valid && kill_rd == r) n--;
      if (n < 0) begin n = 0; m_err = 1'b1; end
      if (n > 3) begin n = 3; m_err = 1'b1; end
      m_cnt[r] = n;
    end
    if (reg_write_w && rd_w != 0) m_regs[rd_w] = result_w;
  endtask

  // Inputs are driven 1ns after a rising edge; this advances to the next one.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_w = 0; rd_w = 0; result_w = 0;
    rs1_d = 0; rs2_d = 0; use_rs1_d = 0; use_rs2_d = 0;
    issue_d = 0; issue_rd_d = 0; issue_reg_write_d = 0;
    kill_valid = 0; kill_rd = 0;
  endtask

  task automatic do_reset();
    idle();
    srst_n = 0;
    model_reset();
    #2;
    srst_n = 1;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    reg_write_w = 1; rd_w = 10; result_w = 32'hA5A5_0F0F;
    issue_d = 1; issue_reg_write_d = 1; issue_rd_d = 12;
    kill_valid = 1; kill_rd = 9;
    cycle();
    idle();
    use_rs1_d = 1; rs1_d = 12; #1;
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL reset_pre_err got=%0b exp=1", sb_err); end
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL reset_pre_stall got=%0b exp=1", stall_d); end
    #2;
    srst_n = 0;
    model_reset();
    #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall_d); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", sb_err); end
    for (int i = 0; i < 32; i++) begin
      rs1_d = 5'(i); rs2_d = 5'(31 - i); #1;
      total++; if (rd1_d !== 32'h0) begin bad++; $display("FAIL reset_rd1 idx=%0d got=%h exp=0", i, rd1_d); end
      total++; if (rd2_d !== 32'h0) begin bad++; $display("FAIL reset_rd2 idx=%0d got=%h exp=0", 31 - i, rd2_d); end
    end
    srst_n = 1;
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    do_reset();
    reg_write_w = 1; rd_w = 5; result_w = 32'hDEAD_BEEF; rs1_d = 5; #1;
    total++; if (rd1_d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_bypass got=%h exp=deadbeef", rd1_d); end
    cycle();
    reg_write_w = 0; #1;
    total++; if (rd1_d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_stored got=%h exp=deadbeef", rd1_d); end
    reg_write_w = 1; rd_w = 0; result_w = 32'h1234; rs1_d = 0; rs2_d = 5; #1;
    total++; if (rd1_d !== 32'h0) begin bad++; $display("FAIL wr_x0_bypass got=%h exp=0", rd1_d); end
    cycle();
    reg_write_w = 0; #1;
    total++; if (rd1_d !== 32'h0) begin bad++; $display("FAIL wr_x0_stored got=%h exp=0", rd1_d); end
    total++; if (rd2_d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_port2 got=%h exp=deadbeef", rd2_d); end
    rs1_d = 5; rs2_d = 5; reg_write_w = 1; rd_w = 5; result_w = 32'h0BAD_F00D; #1;
    total++; if (rd1_d !== 32'h0BAD_F00D || rd2_d !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL wr_same_idx got=%h/%h exp=0badf00d", rd1_d, rd2_d); end
    cycle();
    idle();
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue_d = 1; issue_reg_write_d = 1; issue_rd_d = 7;
    use_rs2_d = 1; rs2_d = 7; #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL raw_issue_cycle got=%0b exp=0", stall_d); end
    cycle();
    issue_d = 0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL raw_hold c=%0d got=%0b exp=1", c, stall_d); end
      cycle();
    end
    reg_write_w = 1; rd_w = 7; result_w = 32'h55; #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL raw_release got=%0b exp=0", stall_d); end
    total++; if (rd2_d !== 32'h55) begin bad++; $display("FAIL raw_data got=%h exp=55", rd2_d); end
    cycle();
    idle();
    issue_d = 1; issue_reg_write_d = 1; issue_rd_d = 7; rs2_d = 7; use_rs2_d = 0;
    cycle();
    issue_d = 0; #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL raw_unused got=%0b exp=0", stall_d); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL raw_err got=%0b exp=0", sb_err); end
    idle();
  endtask

  task automatic test_multi();
    do_reset();
    issue_d = 1; issue_reg_write_d = 1; issue_rd_d = 3;
    cycle(); cycle();
    idle();
    use_rs1_d = 1; rs1_d = 3;
    reg_write_w = 1; rd_w = 3; result_w = 32'h1; #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL multi_first_wb got=%0b exp=1", stall_d); end
    cycle();
    result_w = 32'h2; #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL multi_second_wb got=%0b exp=0", stall_d); end
    cycle();
    reg_write_w = 0;
    issue_d = 1; issue_reg_write_d = 1; issue_rd_d = 3;
    cycle(); cycle();
    issue_d = 0;
    reg_write_w = 1; rd_w = 3; result_w = 32'h3;
    cycle();
    reg_write_w = 0; #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL multi_one_left got=%0b exp=1", stall_d); end
    kill_valid = 1; kill_rd = 3; #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL multi_kill got=%0b exp=0", stall_d); end
    cycle();
    kill_valid = 0; #1;
    total++; if (stall_d !== 1'b0 || sb_err !== 1'b0) begin
      bad++; $display("FAIL multi_end got stall=%0b err=%0b exp=0/0", stall_d, sb_err); end
    idle();
  endtask

  task automatic test_error();
    do_reset();
    kill_valid = 1; kill_rd = 9;
    cycle();
    idle();
    use_rs1_d = 1; rs1_d = 9; #1;
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL err_underflow got=%0b exp=1", sb_err); end
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL err_underflow_cnt got=%0b exp=0", stall_d); end
    do_reset();
    issue_d = 1; issue_reg_write_d = 1; issue_rd_d = 4;
    for (int k = 0; k < 4; k++) cycle();
    idle();
    #1;
    total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL err_overflow got=%0b exp=1", sb_err); end
    use_rs2_d = 1; rs2_d = 4;
    reg_write_w = 1; rd_w = 4; result_w = 32'h44;
    cycle(); cycle();
    reg_write_w = 0; #1;
    total++; if (stall_d !== 1'b1) begin bad++; $display("FAIL err_sat_one_left got=%0b exp=1", stall_d); end
    reg_write_w = 1;
    cycle();
    reg_write_w = 0; #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL err_sat_drained got=%0b exp=0", stall_d); end
    idle();
  endtask

  task automatic test_simultaneous();
    do_reset();
    issue_d = 1; issue_reg_write_d = 1; issue_rd_d = 6;
    cycle();
    reg_write_w = 1; rd_w = 6; result_w = 32'h66;
    kill_valid = 1; kill_rd = 6;
    use_rs1_d = 1; rs1_d = 6; #1;
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL simul_stall got=%0b exp=0", stall_d); end
    cycle();
    issue_d = 0; reg_write_w = 0; kill_valid = 0; #1;
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL simul_err got=%0b exp=0", sb_err); end
    total++; if (stall_d !== 1'b0) begin bad++; $display("FAIL simul_cnt got=%0b exp=0", stall_d); end
    total++; if (rd1_d !== 32'h66) begin bad++; $display("FAIL simul_data got=%h exp=66", rd1_d); end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reg_write_w       = ($urandom_range(0, 2) == 0);
      rd_w              = 5'($urandom_range(0, 7));
      result_w          = $urandom;
      rs1_d             = 5'($urandom_range(0, 7));
      rs2_d             = 5'($urandom_range(0, 7));
      use_rs1_d         = 1'($urandom_range(0, 1));
      use_rs2_d         = 1'($urandom_range(0, 1));
      issue_d           = ($urandom_range(0, 1) == 0);
      issue_rd_d        = 5'($urandom_range(0, 7));
      issue_reg_write_d = ($urandom_range(0, 3) != 0);
      kill_valid        = ($urandom_range(0, 7) == 0);
      kill_rd           = 5'($urandom_range(0, 7));
      #1;
      total++; if (rd1_d !== m_read(rs1_d)) begin bad++; $display("FAIL rnd_rd1 n=%0d got=%h exp=%h", n, rd1_d, m_read(rs1_d)); end
      total++; if (rd2_d !== m_read(rs2_d)) begin bad++; $display("FAIL rnd_rd2 n=%0d got=%h exp=%h", n, rd2_d, m_read(rs2_d)); end
      total++; if (stall_d !== m_stall()) begin bad++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, stall_d, m_stall()); end
      total++; if (sb_err !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%0b exp=%0b", n, sb_err, m_err); end
      if (n == 200) begin
        do_reset();
      end else begin
        cycle();
      end
    end
    idle();
  endtask

  initial begin
    idle();
    srst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_raw_stall();
    test_multi();
    test_error();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
